// File: rtl/serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_pkg
// Shared definitions for the bit-serial adder: the carry-state encoding and
// the one-bit full-adder equations used by the datapath.
// -----------------------------------------------------------------------------
package serial_adder_pkg;

    // Carry state: S0 = no pending carry, S1 = carry pending into next bit.
    typedef enum logic {
        S0 = 1'b0,
        S1 = 1'b1
    } state_t;

    // Sum bit of a one-bit full adder.
    function automatic logic fa_sum(input logic a, input logic b, input logic cin);
        return a ^ b ^ cin;
    endfunction

    // Carry-out of a one-bit full adder (generate, or propagate an incoming carry).
    function automatic logic fa_carry(input logic a, input logic b, input logic cin);
        return (a & b) | (cin & (a ^ b));
    endfunction

endpackage : serial_adder_pkg

// File: rtl/serial_adder_full_adder_bit.sv
// -----------------------------------------------------------------------------
// full_adder_bit
// Purely combinational one-bit full adder.
// Ports:
//   a, b  : operand bits
//   cin   : carry in
//   s     : sum bit
//   cout  : carry out
// -----------------------------------------------------------------------------
module full_adder_bit
    import serial_adder_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    // Full-adder sum and carry equations.
    always_comb begin
        s    = fa_sum(a, b, cin);
        cout = fa_carry(a, b, cin);
    end

endmodule : full_adder_bit

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
// Bit-serial adder built as a two-state Mealy FSM. Operands arrive LSB first,
// one bit pair per clock; the carry between bit positions is the FSM state.
// There is no word length: a final carry stays in the state and appears on sum
// when a zero bit pair is applied on the next cycle.
// Ports:
//   clk   : sole clock, state updates on the rising edge
//   reset : asynchronous, active-high; clears the carry (state S0)
//   a, b  : current operand bits
//   sum   : current sum bit, combinational from a, b and the carry state
// -----------------------------------------------------------------------------
module serial_adder
    import serial_adder_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic a,
    input  logic b,
    output logic sum
);

    state_t ps;          // present state: the pending carry
    state_t ns;          // next state: carry out of the current bit
    logic   fa_s_s;
    logic   fa_cout_s;

    full_adder_bit u_fa (
        .a    (a),
        .b    (b),
        .cin  (ps == S1),
        .s    (fa_s_s),
        .cout (fa_cout_s)
    );

    // Carry state register; reset drops any pending carry immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ps <= S0;
        end else begin
            ps <= ns;
        end
    end

    // Next-state selection: the carry out of this bit becomes the new state.
    // S0 leaves only on a=b=1, S1 leaves only on a=b=0, both covered by cout.
    always_comb begin
        ns = S0;
        case (ps)
            S0: begin
                if (fa_cout_s) ns = S1;
                else           ns = S0;
            end
            S1: begin
                if (fa_cout_s) ns = S1;
                else           ns = S0;
            end
            default: ns = S0;
        endcase
    end

    // Mealy output: no clock latency from a, b or the state.
    always_comb begin
        sum = fa_s_s;
    end

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
// Self-checking bench for serial_adder: truth-table vectors plus directed
// multi-cycle sequences and random 8-bit additions.
// -----------------------------------------------------------------------------
module tb_serial_adder;

    logic clk;
    logic reset;
    logic a;
    logic b;
    logic sum;
    logic ps_obs;

    int n_tests;
    int n_fail;

    serial_adder dut (
        .clk   (clk),
        .reset (reset),
        .a     (a),
        .b     (b),
        .sum   (sum)
    );

    assign ps_obs = dut.ps;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Guard against a hung run.
    initial begin
        #500000;
        $display("FAIL watchdog: time limit expired, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic ps_init;
        logic a;
        logic b;
        logic exp_sum;
        logic exp_ns;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Pulse reset between edges and return inputs to zero.
    task automatic do_reset();
        @(negedge clk);
        a = 1'b0;
        b = 1'b0;
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    // Apply one bit pair across one rising edge with no checks.
    task automatic apply(input logic ai, input logic bi);
        @(negedge clk);
        a = ai;
        b = bi;
        @(posedge clk);
        #1;
    endtask

    // Apply one bit pair, check sum before the edge and state after it.
    task automatic step(input string name, input logic ai, input logic bi,
                        input logic exp_sum, input logic exp_ps);
        @(negedge clk);
        a = ai;
        b = bi;
        #1;
        check({name, ".sum"}, {31'd0, sum}, {31'd0, exp_sum});
        @(posedge clk);
        #1;
        check({name, ".ps"}, {31'd0, ps_obs}, {31'd0, exp_ps});
    endtask

    initial begin
        logic [7:0] opa;
        logic [7:0] opb;
        logic [8:0] got;
        logic [8:0] exp9;
        logic [3:0] sa;
        logic [3:0] sb;
        logic [3:0] es;
        logic [3:0] ep;

        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        a       = 1'b0;
        b       = 1'b0;

        // Truth table: ps, a, b -> sum, ns
        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

        // Reset state, with a=b=1 held during reset.
        @(negedge clk);
        a = 1'b1;
        b = 1'b1;
        #1;
        check("reset.ps", {31'd0, ps_obs}, 32'd0);
        check("reset.sum", {31'd0, sum}, 32'd0);
        @(posedge clk);
        #1;
        check("reset.hold_ps", {31'd0, ps_obs}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("reset.first_edge_ps", {31'd0, ps_obs}, 32'd1);

        // Asynchronous reset while carry pending.
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset.ps", {31'd0, ps_obs}, 32'd0);
        check("async_reset.sum", {31'd0, sum}, 32'd0);
        reset = 1'b0;

        // Exhaustive single step.
        for (int i = 0; i < 8; i++) begin
            do_reset();
            if (vecs[i].ps_init) apply(1'b1, 1'b1);
            step($sformatf("tt%0d", i), vecs[i].a, vecs[i].b, vecs[i].exp_sum, vecs[i].exp_ns);
        end

        // 0110 + 0010 -> 1000, state 0,1,1,0
        do_reset();
        sa = 4'b0110; sb = 4'b0010; es = 4'b1000; ep = 4'b0110;
        for (int i = 0; i < 4; i++) begin
            step($sformatf("add6p2.bit%0d", i), sa[i], sb[i], es[i], ep[i]);
        end

        // 1111 + 0001 then one zero pair -> 10000, carry cleared at end.
        do_reset();
        sa = 4'b1111; sb = 4'b0001; es = 4'b0000; ep = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            step($sformatf("add15p1.bit%0d", i), sa[i], sb[i], es[i], ep[i]);
        end
        step("add15p1.bit4", 1'b0, 1'b0, 1'b1, 1'b0);

        // Mid-operation reset discards carry; next bit is a fresh LSB.
        do_reset();
        apply(1'b1, 1'b1);
        check("midreset.pre_ps", {31'd0, ps_obs}, 32'd1);
        @(negedge clk);
        a = 1'b0;
        b = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("midreset.ps", {31'd0, ps_obs}, 32'd0);
        reset = 1'b0;
        step("midreset.after", 1'b1, 1'b0, 1'b1, 1'b0);

        // Random 8-bit additions, serialized over 9 cycles.
        for (int p = 0; p < 100; p++) begin
            opa  = 8'($urandom_range(0, 255));
            opb  = 8'($urandom_range(0, 255));
            exp9 = {1'b0, opa} + {1'b0, opb};
            got  = 9'd0;
            do_reset();
            for (int k = 0; k < 9; k++) begin
                @(negedge clk);
                a = (k < 8) ? opa[k] : 1'b0;
                b = (k < 8) ? opb[k] : 1'b0;
                #1;
                got[k] = sum;
                @(posedge clk);
            end
            check($sformatf("rand%0d_%0d+%0d", p, opa, opb), {23'd0, got}, {23'd0, exp9});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_serial_adder
